// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the counter-width helper used to size the shift count.
package univ_shift_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHL  = 3'b001,
        MODE_SHR  = 3'b010,
        MODE_ROL  = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_LOAD = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_CLR  = 3'b111
    } mode_e;

    // Ceiling log2; clog2(1) = 0. Used in port widths, so it must stay constant-evaluable.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic logic is_shift(input logic [2:0] mode);
        return (mode == MODE_SHL) || (mode == MODE_SHR) || (mode == MODE_ROL) ||
               (mode == MODE_ROR) || (mode == MODE_ASR);
    endfunction

endpackage

// File: rtl/univ_shift_reg_shift_cnt.sv
// Saturating shift counter with a one-cycle done pulse on reaching WIDTH.
module shift_cnt
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          done
);

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    // NOTE: defaults first so every path assigns cnt_d/done_d and no latch is inferred.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (en) begin
            if (clr) begin
                cnt_d = '0;
            end else if (inc && (cnt_q < CNT_MAX)) begin
                cnt_d  = cnt_q + CNT_ONE;
                done_d = (cnt_q == CNT_MAX - CNT_ONE);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous, active-low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: shifts, rotates, load and clear,
// with a shift counter that flags completion of WIDTH shifts since load.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [2:0]                   mode,
    input  logic [WIDTH-1:0]             din,
    input  logic                         sin_l,
    input  logic                         sin_r,
    output logic [WIDTH-1:0]             dout,
    output logic                         sout_l,
    output logic                         sout_r,
    output logic [clog2(WIDTH+1)-1:0]    cnt,
    output logic                         done
);

    logic [WIDTH-1:0] dout_q, dout_d;

    always_comb begin
        dout_d = dout_q;
        if (en) begin
            case (mode)
                MODE_HOLD: dout_d = dout_q;
                MODE_SHL:  dout_d = {dout_q[WIDTH-2:0], sin_r};
                MODE_SHR:  dout_d = {sin_l, dout_q[WIDTH-1:1]};
                MODE_ROL:  dout_d = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
                MODE_ROR:  dout_d = {dout_q[0], dout_q[WIDTH-1:1]};
                MODE_LOAD: dout_d = din;
                MODE_ASR:  dout_d = {dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
                MODE_CLR:  dout_d = '0;
                default:   dout_d = dout_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) dout_q <= RST_VAL;
        else      dout_q <= dout_d;
    end

    // Load and clear both re-arm the counter; clr takes priority over inc inside shift_cnt.
    shift_cnt #(.WIDTH(WIDTH)) u_shift_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .inc  (is_shift(mode)),
        .clr  ((mode == MODE_LOAD) || (mode == MODE_CLR)),
        .cnt  (cnt),
        .done (done)
    );

    assign dout   = dout_q;
    assign sout_l = dout_q[WIDTH-1];
    assign sout_r = dout_q[0];

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register, the successor to the fixed 4-bit parallel-in/parallel-out register. It supports hold, logical shift left/right, rotate left/right, arithmetic shift right, parallel load and clear, all selected per cycle. A shift counter raises a one-cycle done pulse once WIDTH shifts have completed since the last load, so the block can serve as a serialiser or deserialiser front end.

Parameters:
WIDTH, 8, register width in bits; legal range >= 2.
RST_VAL, 0, value loaded into dout on reset; WIDTH bits wide.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous active-low reset.
en  input  1  clock enable; 0 = all state holds.
mode  input  3  operation select, see Behaviour.
din  input  WIDTH  parallel load data.
sin_l  input  1  serial input entering at the MSB on a logical shift right.
sin_r  input  1  serial input entering at the LSB on a logical shift left.
dout  output  WIDTH  registered parallel output.
sout_l  output  1  equals dout[WIDTH-1]; combinational from the register.
sout_r  output  1  equals dout[0]; combinational from the register.
cnt  output  clog2(WIDTH+1)  shifts since the last load or clear; saturates at WIDTH.
done  output  1  registered one-cycle pulse.

Behaviour:
- Reset: rst sampled low at a rising clk edge -> dout=RST_VAL, cnt=0, done=0. Reset overrides en and mode. Reset mid-operation aborts any count in progress.
- en=0: dout and cnt hold; done=0 on the next edge.
- en=1, decoded by mode (one edge, latency 1 cycle from inputs to dout):
  - 000 hold: dout and cnt unchanged.
  - 001 shift left: dout <= {dout[WIDTH-2:0], sin_r}.
  - 010 shift right: dout <= {sin_l, dout[WIDTH-1:1]}.
  - 011 rotate left: dout <= {dout[WIDTH-2:0], dout[WIDTH-1]}.
  - 100 rotate right: dout <= {dout[0], dout[WIDTH-1:1]}.
  - 101 parallel load: dout <= din; cnt <= 0.
  - 110 arithmetic shift right: dout <= {dout[WIDTH-1], dout[WIDTH-1:1]}; sin_l is ignored.
  - 111 clear: dout <= 0; cnt <= 0. The clear value is 0, not RST_VAL.
- Shift ops are modes 001, 010, 011, 100 and 110. Each shift op increments cnt by 1 when cnt < WIDTH. At cnt == WIDTH the counter holds, with no wrap-around.
- done: 1 on the edge where cnt changes from WIDTH-1 to WIDTH; 0 on every other edge. Further shifts at saturation give no further pulse until a load or clear re-arms the counter.
- Load or clear on the same edge cnt would reach WIDTH: the load/clear wins, cnt=0 and done=0.
- The serial outputs reflect the current register, so the first shifted-out bit is available before the first shift edge.
- Undefined mode values do not exist: all 8 encodings are decoded.

Decomposition:
- Shared package: mode encoding constants (MODE_HOLD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_LOAD, MODE_ASR, MODE_CLR) and the counter-width function clog2.
- Sub-module: shift_cnt. It contains the saturating counter and the done-pulse generator, with inputs inc, clr and en, and outputs cnt and done. The datapath stays in the top module as one case-decoded register.

Test Plan:
- Reset: WIDTH=4, RST_VAL=4'b1010, drive rst=0 for 2 edges while mode=101, din=4'hF -> dout=4'b1010, cnt=0, done=0.
- Load then 4x shift left with sin_r=1,0,1,1 after loading 4'b0000 -> dout sequence 0001, 0010, 0101, 1011. cnt goes 1..4, done=1 only on the 4th edge. A 5th shift gives cnt=4 and done=0.
- Rotate: load 4'b1000, then ROL x4 -> 0001, 0010, 0100, 1000, with sout_l/sout_r tracking. Then ROR x1 -> 0100.
- Arithmetic vs logical: load 4'b1001. ASR -> 1100. Reload, then SHR with sin_l=0 -> 0100.
- Enable and priority: load 4'b0110, shift 3 times, then en=0 for 3 cycles -> dout and cnt frozen, done=0. Issue mode=101 on the edge that would be the 4th shift -> dout=din, cnt=0, no done pulse.
- Reset mid-count: after 2 shifts, assert rst for 1 edge -> dout=RST_VAL, cnt=0. A full 4 subsequent shifts are required before done=1.
